// File: rtl/alu_reg_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the ALU register sequencer.
package alu_reg_sequencer_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned REG_ZERO  = 0;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_SLT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    // Opcodes above SLT are reserved and must never reach the register file.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Issue handshake, register-file ports and ALU ports of the sequencer.
interface alu_reg_sequencer_if
    import alu_reg_sequencer_pkg::*;
#(
    parameter int unsigned word_size  = 32,
    parameter int unsigned addr_width = 5
) ();

    logic                  start;
    logic [OP_W-1:0]       op;
    logic [addr_width-1:0] rs_addr;
    logic [addr_width-1:0] rt_addr;
    logic [addr_width-1:0] rd_addr;
    logic                  ready;
    logic                  done;
    logic                  err;

    logic [addr_width-1:0] rf_ra1;
    logic [addr_width-1:0] rf_ra2;
    logic [word_size-1:0]  rf_rd1;
    logic [word_size-1:0]  rf_rd2;
    logic                  rf_we;
    logic [addr_width-1:0] rf_wa;
    logic [word_size-1:0]  rf_wd;

    logic [OP_W-1:0]       alu_op;
    logic [word_size-1:0]  alu_a;
    logic [word_size-1:0]  alu_b;
    logic [word_size-1:0]  alu_y;

    // Surrounding datapath: issue logic, register file and ALU.
    modport master (
        output start, op, rs_addr, rt_addr, rd_addr, rf_rd1, rf_rd2, alu_y,
        input  ready, done, err, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
        input  alu_op, alu_a, alu_b
    );

    // The sequencer itself.
    modport slave (
        input  start, op, rs_addr, rt_addr, rd_addr, rf_rd1, rf_rd2, alu_y,
        output ready, done, err, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd,
        output alu_op, alu_a, alu_b
    );

endinterface

// File: rtl/alu_reg_sequencer.sv
// Four-cycle controller: read two registers, drive the shared ALU, write back.
module alu_reg_sequencer
    import alu_reg_sequencer_pkg::*;
#(
    parameter int unsigned word_size  = 32,
    parameter int unsigned addr_width = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_reg_sequencer_if.slave bus
);

    state_e                state_q, state_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [addr_width-1:0] rs_q, rs_d;
    logic [addr_width-1:0] rt_q, rt_d;
    logic [addr_width-1:0] rd_q, rd_d;
    logic [word_size-1:0]  a_q, a_d;
    logic [word_size-1:0]  b_q, b_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; flags are decoded from state_d so they register cleanly.
    always_comb begin
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        if (state_q == S_IDLE && bus.start) begin
            op_d = bus.op;
            rs_d = bus.rs_addr;
            rt_d = bus.rt_addr;
            rd_d = bus.rd_addr;
        end
        if (state_q == S_EXEC) begin
            a_d = bus.rf_rd1;
            b_d = bus.rf_rd2;
        end
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_WB);
        err_d   = (state_d == S_WB) && !op_legal(op_q);
        we_d    = (state_d == S_WB) && op_legal(op_q) && (rd_q != addr_width'(REG_ZERO));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    // Completion flags are masked while reset is held so an in-flight write is dropped at once.
    assign bus.ready  = ready_q;
    assign bus.done   = done_q && rst_n;
    assign bus.err    = err_q && rst_n;
    assign bus.rf_we  = we_q && rst_n;
    assign bus.rf_ra1 = rs_q;
    assign bus.rf_ra2 = rt_q;
    assign bus.rf_wa  = rd_q;
    assign bus.rf_wd  = bus.alu_y;
    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;

endmodule
